// File: rtl/rsa_io_bridge.sv
// rsa_io_bridge: PIO command bridge between software and the RSA modexp core.
// Software issues commands over a 4-phase req/ack handshake on to_hw_sig.
// 32-bit words are shifted into wide operands, least-significant word first.
// The core result is latched and handed back one word per READ_RES.
module rsa_io_bridge #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           to_hw_port,
   input  logic [3:0]            to_hw_sig,
   output logic [31:0]           to_sw_port,
   output logic [3:0]            to_sw_sig,
   output logic [32*WORDS-1:0]   msg_out,
   output logic [32*WORDS-1:0]   exp_out,
   output logic [32*WORDS-1:0]   mod_out,
   output logic                  core_start,
   input  logic                  core_done,
   input  logic [32*WORDS-1:0]   core_result
);

   localparam int W     = 32 * WORDS;
   localparam int CNT_W = $clog2(WORDS + 1);
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   localparam logic [2:0] CMD_LOAD_MSG = 3'd1;
   localparam logic [2:0] CMD_LOAD_EXP = 3'd2;
   localparam logic [2:0] CMD_LOAD_MOD = 3'd3;
   localparam logic [2:0] CMD_START    = 3'd4;
   localparam logic [2:0] CMD_READ_RES = 3'd5;
   localparam logic [2:0] CMD_CLEAR    = 3'd6;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t           state_q, state_d;
   logic             exec;
   logic             req;
   logic [2:0]       cmd;

   logic [W-1:0]     msg_q, exp_q, mod_q, result_q;
   logic [CNT_W-1:0] cnt_msg_q, cnt_exp_q, cnt_mod_q;
   logic [IDX_W-1:0] idx_q;
   logic             busy_q, rvld_q, err_q, start_q;
   logic [31:0]      sw_port_q;

   // New word enters at the top; the older words move down one slot, so the
   // first word sent ends up in the least-significant position.
   function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur,
                                            input logic [31:0] word);
      logic [W-1:0] tmp;
      tmp = cur >> 32;
      tmp[W-32 +: 32] = word;
      return tmp;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
      return cnt + CNT_W'(1);
   endfunction

   assign req = to_hw_sig[3];
   assign cmd = to_hw_sig[2:0];

   // Handshake state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Handshake next state; a command fires only on the IDLE->ACK transition
   always_comb begin
      state_d = state_q;
      exec    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               exec    = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (!req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Command execution and core completion; commands see pre-edge busy/result_valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         msg_q     <= '0;
         exp_q     <= '0;
         mod_q     <= '0;
         result_q  <= '0;
         cnt_msg_q <= '0;
         cnt_exp_q <= '0;
         cnt_mod_q <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         rvld_q    <= 1'b0;
         err_q     <= 1'b0;
         start_q   <= 1'b0;
         sw_port_q <= '0;
      end else begin
         start_q <= 1'b0;

         // Completion is only meaningful while a job is outstanding.
         if (core_done && busy_q) begin
            result_q <= core_result;
            busy_q   <= 1'b0;
            rvld_q   <= 1'b1;
         end

         if (exec) begin
            case (cmd)
               CMD_LOAD_MSG: begin
                  if (busy_q || cnt_msg_q == CNT_FULL) err_q <= 1'b1;
                  else begin
                     msg_q     <= shift_in(msg_q, to_hw_port);
                     cnt_msg_q <= cnt_inc(cnt_msg_q);
                  end
               end
               CMD_LOAD_EXP: begin
                  if (busy_q || cnt_exp_q == CNT_FULL) err_q <= 1'b1;
                  else begin
                     exp_q     <= shift_in(exp_q, to_hw_port);
                     cnt_exp_q <= cnt_inc(cnt_exp_q);
                  end
               end
               CMD_LOAD_MOD: begin
                  if (busy_q || cnt_mod_q == CNT_FULL) err_q <= 1'b1;
                  else begin
                     mod_q     <= shift_in(mod_q, to_hw_port);
                     cnt_mod_q <= cnt_inc(cnt_mod_q);
                  end
               end
               CMD_START: begin
                  if (busy_q || cnt_msg_q != CNT_FULL || cnt_exp_q != CNT_FULL ||
                      cnt_mod_q != CNT_FULL) begin
                     err_q <= 1'b1;
                  end else begin
                     start_q <= 1'b1;
                     busy_q  <= 1'b1;
                     rvld_q  <= 1'b0;
                     idx_q   <= '0;
                  end
               end
               CMD_READ_RES: begin
                  // result_valid is always 0 while busy, so this also rejects busy reads.
                  if (!rvld_q) err_q <= 1'b1;
                  else begin
                     sw_port_q <= result_q[idx_q*32 +: 32];
                     idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                  end
               end
               CMD_CLEAR: begin
                  if (busy_q) err_q <= 1'b1;
                  else begin
                     cnt_msg_q <= '0;
                     cnt_exp_q <= '0;
                     cnt_mod_q <= '0;
                     rvld_q    <= 1'b0;
                     err_q     <= 1'b0;
                     idx_q     <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign to_sw_port = sw_port_q;
   assign to_sw_sig  = {state_q == S_ACK, busy_q, rvld_q, err_q};
   assign msg_out    = msg_q;
   assign exp_out    = exp_q;
   assign mod_out    = mod_q;
   assign core_start = start_q;

endmodule

// File: tb/tb_rsa_io_bridge.sv
// tb_rsa_io_bridge: directed bench for rsa_io_bridge with WORDS = 4.
module tb_rsa_io_bridge;

   localparam logic [2:0] C_NOP   = 3'd0;
   localparam logic [2:0] C_MSG   = 3'd1;
   localparam logic [2:0] C_EXP   = 3'd2;
   localparam logic [2:0] C_MOD   = 3'd3;
   localparam logic [2:0] C_START = 3'd4;
   localparam logic [2:0] C_READ  = 3'd5;
   localparam logic [2:0] C_CLEAR = 3'd6;

   localparam logic [127:0] MSG_EXP  = 128'h00000004_00000003_00000002_00000001;
   localparam logic [127:0] EXP3_EXP = 128'h00000013_00000012_00000011_00000000;
   localparam logic [127:0] EXP_EXP  = 128'h00000014_00000013_00000012_00000011;
   localparam logic [127:0] MOD_EXP  = 128'h00000024_00000023_00000022_00000021;
   localparam logic [127:0] RES_VAL  = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  to_hw_port;
   logic [3:0]   to_hw_sig;
   logic [31:0]  to_sw_port;
   logic [3:0]   to_sw_sig;
   logic [127:0] msg_out, exp_out, mod_out;
   logic         core_start;
   logic         core_done;
   logic [127:0] core_result;

   int n_cmp = 0;
   int n_mis = 0;
   int start_cnt = 0;

   rsa_io_bridge #(.WORDS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .to_hw_port (to_hw_port),
      .to_hw_sig  (to_hw_sig),
      .to_sw_port (to_sw_port),
      .to_sw_sig  (to_sw_sig),
      .msg_out    (msg_out),
      .exp_out    (exp_out),
      .mod_out    (mod_out),
      .core_start (core_start),
      .core_done  (core_done),
      .core_result(core_result)
   );

   always #5 clk = ~clk;

   // count start pulses away from the active edge
   always @(negedge clk) if (core_start) start_cnt++;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // full 4-phase handshake for one command
   task automatic do_cmd(input string tag, input logic [2:0] cmd, input logic [31:0] data);
      int n;
      @(negedge clk);
      to_hw_port = data;
      to_hw_sig  = {1'b1, cmd};
      n = 0;
      do begin @(negedge clk); n++; end while (!to_sw_sig[3] && n < 20);
      check({tag, ".ack_hi"}, 128'(to_sw_sig[3]), 128'd1);
      to_hw_sig = 4'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (to_sw_sig[3] && n < 20);
      check({tag, ".ack_lo"}, 128'(to_sw_sig[3]), 128'd0);
   endtask

   task automatic load_n(input string tag, input logic [2:0] cmd,
                         input logic [31:0] base, input int n);
      for (int k = 1; k <= n; k++) do_cmd(tag, cmd, base + 32'(k));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_hi;
      reset       = 1'b1;
      to_hw_port  = '0;
      to_hw_sig   = '0;
      core_done   = 1'b0;
      core_result = '0;
      repeat (3) @(negedge clk);
      check("reset.sig",   128'(to_sw_sig), 128'd0);
      check("reset.port",  128'(to_sw_port), 128'd0);
      check("reset.msg",   msg_out, 128'd0);
      check("reset.start", 128'(core_start), 128'd0);
      reset = 1'b0;

      // req held for 10 cycles: one shift, ack for the whole hold
      @(negedge clk);
      to_hw_port = 32'h1;
      to_hw_sig  = {1'b1, C_MSG};
      ack_hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (to_sw_sig[3]) ack_hi++;
      end
      check("hold.ack_cycles", 128'(ack_hi), 128'd10);
      check("hold.one_shift", msg_out, 128'h00000001_00000000_00000000_00000000);
      to_hw_sig = 4'b0;
      @(negedge clk);
      check("hold.ack_drop", 128'(to_sw_sig[3]), 128'd0);

      load_n("msg", C_MSG, 32'h1, 3);
      check("msg.value", msg_out, MSG_EXP);
      load_n("exp", C_EXP, 32'h10, 3);
      check("exp3.value", exp_out, EXP3_EXP);
      load_n("mod", C_MOD, 32'h20, 4);
      check("mod.value", mod_out, MOD_EXP);
      check("load.no_err", 128'(to_sw_sig), 128'd0);

      // START with exp count 3
      do_cmd("start_short", C_START, 32'h0);
      repeat (2) @(negedge clk);
      check("start_short.sig", 128'(to_sw_sig), 128'b0001);
      check("start_short.no_pulse", 128'(start_cnt), 128'd0);

      // fifth LOAD_MOD
      do_cmd("mod5", C_MOD, 32'h99);
      check("mod5.unchanged", mod_out, MOD_EXP);
      check("mod5.err", 128'(to_sw_sig[0]), 128'd1);

      do_cmd("clear1", C_CLEAR, 32'h0);
      check("clear1.sig", 128'(to_sw_sig), 128'd0);

      // full reload only stays error-free if counts were cleared
      load_n("msg2", C_MSG, 32'h0, 4);
      load_n("exp2", C_EXP, 32'h10, 4);
      load_n("mod2", C_MOD, 32'h20, 4);
      check("reload.no_err", 128'(to_sw_sig), 128'd0);
      check("reload.msg", msg_out, MSG_EXP);
      check("reload.exp", exp_out, EXP_EXP);
      check("reload.mod", mod_out, MOD_EXP);

      do_cmd("start1", C_START, 32'h0);
      check("start1.pulses", 128'(start_cnt), 128'd1);
      check("start1.sig", 128'(to_sw_sig), 128'b0100);

      // LOAD_MSG while busy
      do_cmd("busy_load", C_MSG, 32'h55);
      check("busy_load.msg", msg_out, MSG_EXP);
      check("busy_load.sig", 128'(to_sw_sig), 128'b0101);

      // completion
      @(negedge clk);
      core_done   = 1'b1;
      core_result = RES_VAL;
      @(negedge clk);
      core_done   = 1'b0;
      core_result = '0;
      @(negedge clk);
      check("done.sig", 128'(to_sw_sig), 128'b0011);

      for (int r = 0; r < 5; r++) begin
         do_cmd("read", C_READ, 32'h0);
         check($sformatf("read%0d.port", r), 128'(to_sw_port),
               128'(32'hDEAD0000 + 32'(r % 4)));
      end
      check("read.pulses", 128'(start_cnt), 128'd1);

      // collision: START on the same edge as core_done
      do_cmd("clear2", C_CLEAR, 32'h0);
      load_n("msg3", C_MSG, 32'h0, 4);
      load_n("exp3", C_EXP, 32'h10, 4);
      load_n("mod3", C_MOD, 32'h20, 4);
      do_cmd("start2", C_START, 32'h0);
      check("start2.sig", 128'(to_sw_sig), 128'b0100);
      check("start2.pulses", 128'(start_cnt), 128'd2);
      @(negedge clk);
      to_hw_sig   = {1'b1, C_START};
      core_done   = 1'b1;
      core_result = RES_VAL;
      @(negedge clk);
      core_done   = 1'b0;
      check("collide.sig", 128'(to_sw_sig), 128'b1011);
      to_hw_sig = 4'b0;
      repeat (2) @(negedge clk);
      check("collide.no_pulse", 128'(start_cnt), 128'd2);
      check("collide.idle_sig", 128'(to_sw_sig), 128'b0011);

      // reset while in ACK with busy = 1
      do_cmd("read_pre", C_READ, 32'h0);
      check("read_pre.port", 128'(to_sw_port), 128'hDEAD0000);
      @(negedge clk);
      to_hw_sig = {1'b1, C_START};
      @(negedge clk);
      check("rst_mid.pre_sig", 128'(to_sw_sig), 128'b1101);
      #2 reset = 1'b1;
      #1;
      check("rst_mid.sig",   128'(to_sw_sig), 128'd0);
      check("rst_mid.port",  128'(to_sw_port), 128'd0);
      check("rst_mid.msg",   msg_out, 128'd0);
      check("rst_mid.mod",   mod_out, 128'd0);
      check("rst_mid.start", 128'(core_start), 128'd0);
      to_hw_sig = 4'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      core_done   = 1'b1;
      core_result = RES_VAL;
      @(negedge clk);
      core_done = 1'b0;
      @(negedge clk);
      check("post_rst_done.sig",  128'(to_sw_sig), 128'd0);
      check("post_rst_done.port", 128'(to_sw_port), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
